multdiv_sequencer: RTL and testbench

//   Sequences the shared iterative multiply/divide datapath for the processor's multdiv unit.

---
 rtl/multdiv_pkg.sv | 28 ++
 rtl/multdiv_step_counter.sv | 47 ++++
 rtl/multdiv_sequencer.sv | 144 ++++++++++++++
 tb/tb_multdiv_sequencer.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/multdiv_pkg.sv
// rtl/multdiv_pkg.sv - shared constants and state encoding for the multdiv sequencer
//
// Purpose : step-count defaults, FSM state encoding and op-type constants
//           used by multdiv_sequencer and multdiv_step_counter.
// Ports   : none (package)
package multdiv_pkg;

   localparam int MULT_STEPS_DEF = 16;   // radix-4 Booth iterations, 32-bit operands
   localparam int DIV_STEPS_DEF  = 32;   // restoring-divide iterations
   localparam int CNT_W_DEF      = 5;    // holds max(steps)-1

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_LOAD  = 3'd1,
      ST_RUN_M = 3'd2,
      ST_RUN_D = 3'd3,
      ST_FIN   = 3'd4
   } state_e;

   localparam logic OP_MULT = 1'b0;
   localparam logic OP_DIV  = 1'b1;

   // Multiply wins when both start strobes arrive together.
   function automatic logic start_is_div(input logic mult_req, input logic div_req);
      return div_req & ~mult_req;
   endfunction

endpackage

// File: rtl/multdiv_step_counter.sv
// rtl/multdiv_step_counter.sv - iteration counter with sync clear and terminal-count compare
//
// Purpose : counts datapath iterations; holds at the terminal value instead of wrapping.
// Ports   : clk     in  clock
//           rst_n   in  asynchronous reset, active-low
//           clr_i   in  synchronous clear to 0 (wins over enable)
//           en_i    in  advance by one
//           last_i  in  index of the final iteration (N-1)
//           cnt_o   out current count
//           tc_o    out count equals last_i
module multdiv_step_counter #(
   parameter int CNT_W = multdiv_pkg::CNT_W_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr_i,
   input  logic             en_i,
   input  logic [CNT_W-1:0] last_i,
   output logic [CNT_W-1:0] cnt_o,
   output logic             tc_o
);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   assign tc_o  = (cnt_q == last_i);
   assign cnt_o = cnt_q;

   // Holding at terminal count keeps a 32-step divide from wrapping a 5-bit counter.
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (en_i && !tc_o) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/multdiv_sequencer.sv
// rtl/multdiv_sequencer.sv - control sequencer for the shared iterative multiply/divide datapath
//
// Purpose : accepts multiply/divide start pulses, drives operand latch, datapath clear and
//           per-step enables, and reports result-ready / exception to the pipeline.
// Ports   : clk            in  rising-edge clock
//           clr            in  asynchronous reset, active-low
//           ctrl_MULT      in  start multiply (sampled each edge)
//           ctrl_DIV       in  start divide (sampled each edge)
//           div_zero       in  datapath: latched divisor is zero
//           mult_ovf       in  datapath: product overflows 32 bits
//           latch_ops      out load operand registers
//           dp_clr         out clear product/remainder registers
//           mult_en        out one Booth step
//           div_en         out one divide step
//           step           out current iteration index while running, else 0
//           sel_div        out result mux select, 1 = last accepted op was a divide
//           busy           out op in LOAD or RUN
//           data_resultRDY out one-cycle result-valid pulse
//           data_exception out exception flag, only alongside data_resultRDY
module multdiv_sequencer
   import multdiv_pkg::*;
#(
   parameter int MULT_STEPS = MULT_STEPS_DEF,
   parameter int DIV_STEPS  = DIV_STEPS_DEF,
   parameter int CNT_W      = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             clr,
   input  logic             ctrl_MULT,
   input  logic             ctrl_DIV,
   input  logic             div_zero,
   input  logic             mult_ovf,
   output logic             latch_ops,
   output logic             dp_clr,
   output logic             mult_en,
   output logic             div_en,
   output logic [CNT_W-1:0] step,
   output logic             sel_div,
   output logic             busy,
   output logic             data_resultRDY,
   output logic             data_exception
);

   localparam logic [CNT_W-1:0] MULT_LAST = CNT_W'(MULT_STEPS - 1);
   localparam logic [CNT_W-1:0] DIV_LAST  = CNT_W'(DIV_STEPS - 1);

   state_e     state_q, state_d;
   logic       sel_div_q, sel_div_d;
   logic       start;
   logic       running;
   logic       cnt_tc;
   logic [CNT_W-1:0] cnt;

   assign start   = ctrl_MULT | ctrl_DIV;
   assign running = (state_q == ST_RUN_M) || (state_q == ST_RUN_D);

   multdiv_step_counter #(
      .CNT_W (CNT_W)
   ) u_cnt (
      .clk    (clk),
      .rst_n  (clr),
      .clr_i  (state_q == ST_LOAD),
      .en_i   (running),
      .last_i ((sel_div_q == OP_DIV) ? DIV_LAST : MULT_LAST),
      .cnt_o  (cnt),
      .tc_o   (cnt_tc)
   );

   // A start from any state restarts at LOAD; in LOAD/RUN this abandons the
   // current op, in FIN the finishing op still gets its result pulse.
   always_comb begin
      state_d   = state_q;
      sel_div_d = sel_div_q;
      if (start) begin
         state_d   = ST_LOAD;
         sel_div_d = start_is_div(ctrl_MULT, ctrl_DIV);
      end else begin
         case (state_q)
            ST_IDLE:  state_d = ST_IDLE;
            ST_LOAD: begin
               if (sel_div_q == OP_DIV) begin
                  state_d = div_zero ? ST_FIN : ST_RUN_D;
               end else begin
                  state_d = ST_RUN_M;
               end
            end
            ST_RUN_M,
            ST_RUN_D: begin
               if (cnt_tc) begin
                  state_d = ST_FIN;
               end
            end
            ST_FIN:   state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         state_q   <= ST_IDLE;
         sel_div_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         sel_div_q <= sel_div_d;
      end
   end

   always_comb begin
      latch_ops      = 1'b0;
      dp_clr         = 1'b0;
      mult_en        = 1'b0;
      div_en         = 1'b0;
      busy           = 1'b0;
      data_resultRDY = 1'b0;
      data_exception = 1'b0;
      step           = '0;
      case (state_q)
         ST_LOAD: begin
            latch_ops = 1'b1;
            dp_clr    = 1'b1;
            busy      = 1'b1;
         end
         ST_RUN_M: begin
            mult_en = 1'b1;
            busy    = 1'b1;
            step    = cnt;
         end
         ST_RUN_D: begin
            div_en = 1'b1;
            busy   = 1'b1;
            step   = cnt;
         end
         ST_FIN: begin
            data_resultRDY = 1'b1;
            data_exception = (sel_div_q == OP_MULT) ? mult_ovf : div_zero;
         end
         default: ;
      endcase
   end

   assign sel_div = sel_div_q;

endmodule

// File: tb/tb_multdiv_sequencer.sv
// tb/tb_multdiv_sequencer.sv - self-checking bench for multdiv_sequencer
module tb_multdiv_sequencer;

   logic       clk = 1'b0;
   logic       clr;
   logic       ctrl_MULT, ctrl_DIV, div_zero, mult_ovf;
   logic       latch_ops, dp_clr, mult_en, div_en, sel_div, busy;
   logic       data_resultRDY, data_exception;
   logic [4:0] step;
   logic [13:0] act_vec;

   int errors = 0;
   int checks = 0;
   int cyc    = 0;

   multdiv_sequencer dut (
      .clk            (clk),
      .clr            (clr),
      .ctrl_MULT      (ctrl_MULT),
      .ctrl_DIV       (ctrl_DIV),
      .div_zero       (div_zero),
      .mult_ovf       (mult_ovf),
      .latch_ops      (latch_ops),
      .dp_clr         (dp_clr),
      .mult_en        (mult_en),
      .div_en         (div_en),
      .step           (step),
      .sel_div        (sel_div),
      .busy           (busy),
      .data_resultRDY (data_resultRDY),
      .data_exception (data_exception)
   );

   always #5 clk = ~clk;

   assign act_vec = {latch_ops, dp_clr, mult_en, div_en, step, sel_div, busy,
                     data_resultRDY, data_exception};

   // Timeline model: an op is described by its age in cycles since the start
   // was sampled (1 = operand load) and the age at which its result appears.
   bit m_active = 0;
   bit m_div    = 0;
   bit m_sel    = 0;
   int m_age    = 0;
   int m_fin    = 0;

   task automatic model_edge();
      if (!clr) begin
         m_active = 0;
         m_sel    = 0;
      end else if (ctrl_MULT || ctrl_DIV) begin
         m_active = 1;
         m_age    = 1;
         m_div    = ctrl_DIV && !ctrl_MULT;
         m_sel    = m_div;
         m_fin    = (m_div ? 32 : 16) + 2;
      end else if (m_active) begin
         if (m_age == 1 && m_div && div_zero) m_fin = 2;
         m_age++;
         if (m_age > m_fin) m_active = 0;
      end
   endtask

   function automatic logic [13:0] expect_vec();
      bit ld, run, rdy, exc, bsy;
      logic [4:0] st;
      ld  = m_active && m_age == 1;
      run = m_active && m_age >= 2 && m_age < m_fin;
      rdy = m_active && m_age == m_fin;
      bsy = m_active && m_age < m_fin;
      st  = run ? 5'(m_age - 2) : 5'd0;
      exc = rdy && (m_div ? div_zero : mult_ovf);
      return {ld, ld, run && !m_div, run && m_div, st, m_sel, bsy, rdy, exc};
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h at cycle %0d", tag, obs, exp, cyc);
      end
   endtask

   task automatic cycle();
      logic ok;
      @(posedge clk);
      model_edge();
      cyc++;
      #1;
      check("outputs", 32'(act_vec), 32'(expect_vec()));
      ok = ($countones({latch_ops, mult_en, div_en, data_resultRDY}) <= 1);
      check("onehot", {31'b0, ok}, 32'd1);
   endtask

   task automatic start_op(input bit m, input bit d);
      ctrl_MULT = m;
      ctrl_DIV  = d;
      cycle();
      ctrl_MULT = 0;
      ctrl_DIV  = 0;
   endtask

   // n counts cycles since the start edge (1 = load cycle); -1 if no result in time.
   task automatic wait_rdy(input int limit, output int n);
      n = 1;
      while (!data_resultRDY && n < limit) begin
         cycle();
         n++;
      end
      if (!data_resultRDY) n = -1;
   endtask

   initial begin
      int n;
      clr = 0; ctrl_MULT = 0; ctrl_DIV = 0; div_zero = 0; mult_ovf = 0;
      repeat (2) cycle();
      clr = 1;
      repeat (2) cycle();

      // plain multiply
      start_op(1, 0);
      wait_rdy(40, n);
      check("mult_latency", n, 18);
      repeat (3) cycle();

      // plain divide
      start_op(0, 1);
      wait_rdy(60, n);
      check("div_latency", n, 34);
      repeat (3) cycle();
      check("sel_div_hold", sel_div, 1);

      // divide by zero
      div_zero = 1;
      start_op(0, 1);
      wait_rdy(10, n);
      check("dz_latency", n, 2);
      check("dz_exception", data_exception, 1);
      div_zero = 0;
      repeat (2) cycle();

      // simultaneous starts, multiply wins, overflow reported
      mult_ovf = 1;
      start_op(1, 1);
      check("both_sel_div", sel_div, 0);
      wait_rdy(40, n);
      check("both_latency", n, 18);
      check("both_exception", data_exception, 1);
      mult_ovf = 0;
      cycle();

      // divide aborted by a multiply 10 cycles later
      start_op(0, 1);
      repeat (9) cycle();
      start_op(1, 0);
      wait_rdy(40, n);
      check("abort_latency", n, 18);
      check("abort_sel_div", sel_div, 0);
      repeat (2) cycle();

      // async reset in the middle of a multiply
      start_op(1, 0);
      repeat (8) cycle();
      check("pre_reset_step", step, 7);
      #2 clr = 0;
      #1;
      check("async_reset", 32'(act_vec), 32'd0);
      m_active = 0;
      m_sel    = 0;
      cycle();
      clr = 1;
      repeat (25) cycle();

      // start during FIN gives back-to-back results 18 cycles apart
      start_op(1, 0);
      wait_rdy(40, n);
      check("b2b_first", n, 18);
      start_op(1, 0);
      wait_rdy(40, n);
      check("b2b_gap", n, 18);
      repeat (2) cycle();

      // random traffic against the timeline model
      for (int i = 0; i < 600; i++) begin
         int r;
         r = $urandom_range(0, 29);
         ctrl_MULT = (r == 0) || (r == 2);
         ctrl_DIV  = (r == 1) || (r == 2);
         mult_ovf  = 1'($urandom_range(0, 1));
         if (!m_active) div_zero = ($urandom_range(0, 3) == 0);
         cycle();
      end
      ctrl_MULT = 0;
      ctrl_DIV  = 0;
      repeat (40) cycle();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
